// File: rtl/fir_power_monitor_pkg.sv
// ----------------------------------------------------------------------------
// fir_power_monitor_pkg
// Shared constants for the FIR output power monitor.
//   - default parameter values
//   - FSM state encodings (SETTLE / ACCUM)
//   - width helpers for the energy output and the window accumulator
// ----------------------------------------------------------------------------
package fir_power_monitor_pkg;

    localparam int DEF_NB_INPUT       = 18;
    localparam int DEF_LOG2_WIN       = 6;
    localparam int DEF_SETTLE_SAMPLES = 16;

    typedef logic [0:0] state_t;

    localparam state_t ST_SETTLE = 1'b0;
    localparam state_t ST_ACCUM  = 1'b1;

    // Width of the mean-square output (square of a sample).
    function automatic int nb_energy(input int nb_input);
        return 2 * nb_input;
    endfunction

    // Width of the window accumulator: a sum of 2^log2_win squares never overflows.
    function automatic int nb_acc(input int nb_input, input int log2_win);
        return 2 * nb_input + log2_win;
    endfunction

endpackage

// File: rtl/fir_power_monitor_if.sv
// ----------------------------------------------------------------------------
// fir_power_monitor_if
// Sample stream in, window measurements out.
// Handshake: i_valid is a pure strobe with no ready/back-pressure. A sample
// on i_data is consumed on every rising edge where i_valid is high. o_valid
// is a one-cycle pulse marking the cycle in which o_energy/o_peak took new
// values. Those values then hold until the next pulse.
// Ports:
//   i_valid  : sample strobe (master -> slave)
//   i_data   : signed sample, NB_INPUT bits (master -> slave)
//   o_energy : unsigned mean square of last window, 2*NB_INPUT bits
//   o_peak   : unsigned max |sample| of last window, NB_INPUT bits
//   o_valid  : measurement-updated pulse
// ----------------------------------------------------------------------------
interface fir_power_monitor_if #(
    parameter int NB_INPUT = 18
);
    logic                         i_valid;
    logic signed [NB_INPUT-1:0]   i_data;
    logic [2*NB_INPUT-1:0]        o_energy;
    logic [NB_INPUT-1:0]          o_peak;
    logic                         o_valid;

    modport master (
        output i_valid, i_data,
        input  o_energy, o_peak, o_valid
    );

    modport slave (
        input  i_valid, i_data,
        output o_energy, o_peak, o_valid
    );
endinterface

// File: rtl/fir_power_monitor_sample_abs_sq.sv
// ----------------------------------------------------------------------------
// sample_abs_sq
// Stage-1 register of the power monitor: captures |x|, x*x and the
// in-window / last-of-window tags of each valid sample.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid, i_data     : incoming sample and strobe
//   i_accum, i_last     : sample belongs to a window / closes that window
//   o_valid             : a fresh sample is held this cycle
//   o_accum, o_last     : registered tags
//   o_abs, o_sq         : registered |x| (NB_INPUT) and x*x (2*NB_INPUT)
// ----------------------------------------------------------------------------
module sample_abs_sq #(
    parameter int NB_INPUT = 18
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic signed [NB_INPUT-1:0] i_data,
    input  logic                       i_accum,
    input  logic                       i_last,
    output logic                       o_valid,
    output logic                       o_accum,
    output logic                       o_last,
    output logic [NB_INPUT-1:0]        o_abs,
    output logic [2*NB_INPUT-1:0]      o_sq
);
    logic [NB_INPUT-1:0]          raw;
    logic [NB_INPUT-1:0]          abs_d;
    logic signed [2*NB_INPUT-1:0] data_ext;
    logic signed [2*NB_INPUT-1:0] sq_d;

    logic                    valid_q, accum_q, last_q;
    logic [NB_INPUT-1:0]     abs_q;
    logic [2*NB_INPUT-1:0]   sq_q;

    // Unsigned negate keeps |most negative| = 2^(NB_INPUT-1) exact.
    assign raw      = i_data;
    assign abs_d    = raw[NB_INPUT-1] ? (~raw + NB_INPUT'(1)) : raw;
    assign data_ext = (2*NB_INPUT)'(i_data);
    assign sq_d     = data_ext * data_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            accum_q <= 1'b0;
            last_q  <= 1'b0;
            abs_q   <= '0;
            sq_q    <= '0;
        end else begin
            // The fresh flag drops when no sample arrives so stage 2 never
            // consumes the same sample twice.
            valid_q <= i_valid;
            if (i_valid) begin
                accum_q <= i_accum;
                last_q  <= i_last;
                abs_q   <= abs_d;
                sq_q    <= sq_d;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_accum = accum_q;
    assign o_last  = last_q;
    assign o_abs   = abs_q;
    assign o_sq    = sq_q;
endmodule

// File: rtl/fir_power_monitor.sv
// ----------------------------------------------------------------------------
// fir_power_monitor
// Measures mean-square energy and absolute peak of a signed sample stream
// over back-to-back windows of 2^LOG2_WIN valid samples, after discarding
// SETTLE_SAMPLES start-up samples.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : fir_power_monitor_if.slave (i_valid/i_data in,
//                  o_energy/o_peak/o_valid out)
//   o_dbg_state  : current FSM state (ST_SETTLE / ST_ACCUM)
// ----------------------------------------------------------------------------
module fir_power_monitor
    import fir_power_monitor_pkg::*;
#(
    parameter int NB_INPUT       = DEF_NB_INPUT,
    parameter int LOG2_WIN       = DEF_LOG2_WIN,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fir_power_monitor_if.slave   bus,
    output state_t               o_dbg_state
);
    localparam int NB_ENERGY  = nb_energy(NB_INPUT);
    localparam int NB_ACC     = nb_acc(NB_INPUT, LOG2_WIN);
    localparam int NB_SETTLE  = (SETTLE_SAMPLES > 2) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam logic [NB_SETTLE-1:0] SETTLE_LAST =
        NB_SETTLE'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam state_t RESET_STATE = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;

    state_t                  state_q, state_d;
    logic [NB_SETTLE-1:0]    settle_q, settle_d;
    logic [LOG2_WIN-1:0]     win_q, win_d;
    logic                    in_accum, win_last;

    logic                    s1_valid, s1_accum, s1_last;
    logic [NB_INPUT-1:0]     s1_abs;
    logic [NB_ENERGY-1:0]    s1_sq;

    logic [NB_ACC-1:0]       acc_q, acc_sum;
    logic [NB_INPUT-1:0]     peak_q, peak_max;
    logic [NB_ENERGY-1:0]    energy_q;
    logic [NB_INPUT-1:0]     peak_out_q;
    logic                    valid_out_q;

    assign in_accum = (state_q == ST_ACCUM);
    assign win_last = in_accum && (win_q == {LOG2_WIN{1'b1}});

    // Settle counter, window counter and FSM advance on valid samples only.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        if (bus.i_valid) begin
            if (in_accum) begin
                win_d = win_q + LOG2_WIN'(1);
            end else if (settle_q == SETTLE_LAST) begin
                state_d  = ST_ACCUM;
                settle_d = '0;
            end else begin
                settle_d = settle_q + NB_SETTLE'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= RESET_STATE;
            settle_q <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
        end
    end

    sample_abs_sq #(.NB_INPUT(NB_INPUT)) u_stage1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_valid),
        .i_data  (bus.i_data),
        .i_accum (in_accum),
        .i_last  (win_last),
        .o_valid (s1_valid),
        .o_accum (s1_accum),
        .o_last  (s1_last),
        .o_abs   (s1_abs),
        .o_sq    (s1_sq)
    );

    assign acc_sum  = acc_q + NB_ACC'(s1_sq);
    assign peak_max = (s1_abs > peak_q) ? s1_abs : peak_q;

    // Stage 2: the last sample of a window publishes and clears in one edge,
    // so the next window starts without a gap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q       <= '0;
            peak_q      <= '0;
            energy_q    <= '0;
            peak_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            if (s1_valid && s1_accum) begin
                if (s1_last) begin
                    energy_q    <= acc_sum[NB_ACC-1:LOG2_WIN];
                    peak_out_q  <= peak_max;
                    valid_out_q <= 1'b1;
                    acc_q       <= '0;
                    peak_q      <= '0;
                end else begin
                    acc_q  <= acc_sum;
                    peak_q <= peak_max;
                end
            end
        end
    end

    assign bus.o_energy = energy_q;
    assign bus.o_peak   = peak_out_q;
    assign bus.o_valid  = valid_out_q;
    assign o_dbg_state  = state_q;
endmodule
